bcd2bin: RTL and testbench
==========================

Name: bcd2bin

Overview:
- Sequential BCD-to-binary converter using reverse double dabble: shift right one bit per step, then subtract 3 from any BCD digit ≥ 8.
- Inverse of the existing binary-to-BCD converter. Same start/data-valid handshake, so the two can be chained for round-trip checks, or used on display/keypad input paths.
- One conversion in flight at a time; the input is latched on start.

Parameters:
- DECIMAL_DIGITS, 2, number of packed BCD input digits.
- OUTPUT_WIDTH, 7, binary result width. Must satisfy 2^OUTPUT_WIDTH > 10^DECIMAL_DIGITS - 1. Elaboration fails via generate-time check otherwise.

Ports:
- i_Clock  in  1  system clock, rising-edge.
- i_Reset  in  1  asynchronous, active-high reset.
- i_BCD  in  DECIMAL_DIGITS*4  packed BCD; digit 0 in bits [3:0].
- i_Start  in  1  start request; level-sampled in IDLE only.
- o_Binary  out  OUTPUT_WIDTH  converted result; holds until the next completion.
- o_DV  out  1  one-cycle pulse: o_Binary is valid/updated.
- o_Busy  out  1  high while converting (state != IDLE).
- o_Err  out  1  invalid-digit flag, qualified by o_DV (see Optional Feature).

Behaviour:
- Reset (async, i_Reset=1): state=IDLE, count=0, working register=0, o_Binary=0, o_DV=0, o_Busy=0, o_Err=0. Reset mid-conversion aborts it; no o_DV follows.
- Working register: {bcd[4*D-1:0], bin[OUTPUT_WIDTH-1:0]}, right-shifted as one vector.
- IDLE: if i_Start=1 at an edge, then bcd<=i_BCD, bin<=0, count<=0, next state SHIFT. Otherwise hold.
- SHIFT: logical right shift of the working register by 1; count<=count+1.
  - If count==OUTPUT_WIDTH-1: o_Binary<=shifted bin, o_DV<=1, next state IDLE.
  - Otherwise next state ADJUST.
- ADJUST: each BCD nibble ≥ 8 becomes nibble-3, all in parallel. Next state SHIFT.
- Latency: OUTPUT_WIDTH shifts + (OUTPUT_WIDTH-1) adjusts = 2*OUTPUT_WIDTH-1 edges after the edge sampling i_Start.
  - o_DV is high in the cycle following that edge. Default: 13 edges.
- o_DV is 0 in all other cycles.
- Back-to-back: if i_Start is still high in the cycle o_DV is high (state=IDLE), a new conversion starts at that edge, giving a throughput of 1 result per 2*OUTPUT_WIDTH cycles.
- i_Start and i_BCD changes while busy are ignored; the value latched at start is converted.
- Nibble arithmetic is 4-bit unsigned. Subtract only when ≥ 8, so no underflow.
- Counter width is $clog2(OUTPUT_WIDTH)+1.

Optional Feature:
- Macro BCD2BIN_DIGIT_CHECK_EN.
- Defined:
  - At start, any i_BCD nibble > 9 sets a sticky err flag for that conversion.
  - At completion: o_Err=1 with o_DV and o_Binary forced to 0.
  - o_Err is cleared at the next start or reset.
- Undefined:
  - o_Err tied to 0.
  - Invalid nibbles are converted arithmetically (nibble weighted ×10^k) with no flagging.

Decomposition:
- Package bcd_pkg holds:
  - state enum IDLE/SHIFT/ADJUST;
  - constants BCD_ADJ_THRESH=8, BCD_ADJ_VAL=3, BCD_MAX_DIGIT=9.
- The package is shared with the bin2bcd side (which uses threshold 5/add 3).
- One natural sub-module: bcd_digit_sub3. Combinational, 4-bit in/out: out = (in ≥ 8) ? in-3 : in. It is instantiated DECIMAL_DIGITS times via generate.

Test Plan:
- Defaults, i_BCD=8'h31, pulse i_Start -> o_DV for one cycle after exactly 13 edges, o_Binary=7'd31, o_Busy high for 13 cycles.
- i_BCD=8'h18 changed to 8'h99 mid-conversion -> o_Binary=7'd18 (latched value).
- i_BCD=8'h00 and 8'h99 -> o_Binary=0 and 99 respectively, o_Err=0.
- i_Start held high, i_BCD=8'h42 -> o_DV pulses every 14 cycles, each with o_Binary=7'd42.
- i_Reset asserted 5 cycles into conversion of 8'h77 -> all outputs 0 immediately, no o_DV, next start converts correctly.
- With BCD2BIN_DIGIT_CHECK_EN, i_BCD=8'h1A -> o_DV with o_Err=1, o_Binary=0. Without the macro -> o_Binary=7'd20, o_Err=0.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD conversion definitions: FSM states and digit-adjust constants.
// The binary-to-BCD side uses this package too, with threshold 5 and add 3.
package bcd_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, ADJUST} state_e;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;
  localparam logic [3:0] BCD_ADJ_VAL    = 4'd3;
  localparam logic [3:0] BCD_MAX_DIGIT  = 4'd9;

endpackage

// File: rtl/bcd2bin_if.sv
// Start/data-valid handshake bundle for the BCD-to-binary converter.
interface bcd2bin_if #(
  parameter int DECIMAL_DIGITS = 2,
  parameter int OUTPUT_WIDTH   = 7
);
  logic [4*DECIMAL_DIGITS-1:0] i_BCD;
  logic                        i_Start;
  logic [OUTPUT_WIDTH-1:0]     o_Binary;
  logic                        o_DV;
  logic                        o_Busy;
  logic                        o_Err;

  modport master (output i_BCD, i_Start, input o_Binary, o_DV, o_Busy, o_Err);
  modport slave  (input i_BCD, i_Start, output o_Binary, o_DV, o_Busy, o_Err);
endinterface

// File: rtl/bcd_digit_sub3.sv
// One reverse-double-dabble digit correction: nibbles >= 8 drop by 3.
module bcd_digit_sub3
  import bcd_pkg::*;
(
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);
  assign d_o = (d_i >= BCD_ADJ_THRESH) ? d_i - BCD_ADJ_VAL : d_i;
endmodule

// File: rtl/bcd2bin.sv
// Sequential BCD-to-binary converter (reverse double dabble, 1 bit per SHIFT).
// Optional macro BCD2BIN_DIGIT_CHECK_EN flags nibbles > 9 via o_Err.
module bcd2bin
  import bcd_pkg::*;
#(
  parameter int DECIMAL_DIGITS = 2,
  parameter int OUTPUT_WIDTH   = 7
) (
  input  logic      i_Clock,
  input  logic      i_Reset,
  bcd2bin_if.slave  bus
);
  localparam int CW = $clog2(OUTPUT_WIDTH) + 1;
  localparam int BW = 4 * DECIMAL_DIGITS;
  localparam logic [CW-1:0] LAST = CW'(OUTPUT_WIDTH - 1);

  if ((64'd1 << OUTPUT_WIDTH) <= 64'(10 ** DECIMAL_DIGITS) - 64'd1) begin : g_bad_width
    $error("bcd2bin: OUTPUT_WIDTH too small for DECIMAL_DIGITS");
  end

  state_e                             state_q, state_d;
  logic [CW-1:0]                      cnt_q, cnt_d;
  logic [DECIMAL_DIGITS-1:0][3:0]     bcd_q, bcd_d, bcd_adj;
  logic [OUTPUT_WIDTH-1:0]            bin_q, bin_d, out_q, out_d;
  logic                               dv_q, dv_d;
  logic [BW+OUTPUT_WIDTH-1:0]         work_sh;
  logic                               start_w, done_w, force_zero;

  for (genvar g = 0; g < DECIMAL_DIGITS; g++) begin : g_dig
    bcd_digit_sub3 u_sub3 (.d_i(bcd_q[g]), .d_o(bcd_adj[g]));
  end

  assign work_sh = {bcd_q, bin_q} >> 1;
  assign start_w = (state_q == IDLE) && bus.i_Start;
  assign done_w  = (state_q == SHIFT) && (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    out_d   = out_q;
    dv_d    = 1'b0;
    case (state_q)
      IDLE: if (bus.i_Start) begin
        bcd_d   = bus.i_BCD;
        bin_d   = '0;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        {bcd_d, bin_d} = work_sh;
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // An invalid-digit conversion reports zero rather than garbage.
          out_d   = force_zero ? '0 : work_sh[OUTPUT_WIDTH-1:0];
          dv_d    = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = ADJUST;
        end
      end
      ADJUST: begin
        bcd_d   = bcd_adj;
        state_d = SHIFT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bcd_q   <= '0;
      bin_q   <= '0;
      out_q   <= '0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      out_q   <= out_d;
      dv_q    <= dv_d;
    end
  end

`ifdef BCD2BIN_DIGIT_CHECK_EN
  logic [DECIMAL_DIGITS-1:0] bad_dig;
  logic                      err_q, err_out_q;

  for (genvar g = 0; g < DECIMAL_DIGITS; g++) begin : g_chk
    assign bad_dig[g] = bus.i_BCD[4*g +: 4] > BCD_MAX_DIGIT;
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      err_q     <= 1'b0;
      err_out_q <= 1'b0;
    end else if (start_w) begin
      err_q     <= |bad_dig;
      err_out_q <= 1'b0;
    end else if (done_w) begin
      err_out_q <= err_q;
    end
  end

  assign force_zero = err_q;
  assign bus.o_Err  = err_out_q;
`else
  assign force_zero = 1'b0;
  assign bus.o_Err  = 1'b0;
`endif

  assign bus.o_Binary = out_q;
  assign bus.o_DV     = dv_q;
  assign bus.o_Busy   = (state_q != IDLE);

endmodule

// File: tb/tb_bcd2bin.sv
// Directed bench for bcd2bin: latency, latching, back-to-back, reset abort, bad digit.
module tb_bcd2bin;
  logic i_Clock = 1'b0;
  logic i_Reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  bcd2bin_if #(.DECIMAL_DIGITS(2), .OUTPUT_WIDTH(7)) bus ();

  bcd2bin #(.DECIMAL_DIGITS(2), .OUTPUT_WIDTH(7)) dut (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .bus     (bus)
  );

  always #5 i_Clock = ~i_Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Pulse start with bcd; optionally rewrite i_BCD at negedge index chg_at.
  task automatic conv(input logic [7:0] bcd, input int chg_at, input logic [7:0] chg_val,
                      output int edges, output int busy_n, output logic [6:0] res,
                      output logic err);
    @(negedge i_Clock);
    bus.i_BCD   = bcd;
    bus.i_Start = 1'b1;
    @(posedge i_Clock);
    edges  = 0;
    busy_n = 0;
    res    = 'x;
    err    = 1'bx;
    for (int k = 0; k < 40; k++) begin
      @(negedge i_Clock);
      bus.i_Start = 1'b0;
      if (k == chg_at) bus.i_BCD = chg_val;
      if (bus.o_Busy) busy_n++;
      if (bus.o_DV) begin
        res = bus.o_Binary;
        err = bus.o_Err;
        break;
      end
      @(posedge i_Clock);
      edges++;
    end
  endtask

  initial begin
    int         edges, busy_n, last_dv, dv_seen;
    int         dv_at[$];
    logic [6:0] res;
    logic       err;

    bus.i_BCD   = 8'h00;
    bus.i_Start = 1'b0;
    #12;
    chk("rst_bin",  bus.o_Binary, 0);
    chk("rst_dv",   bus.o_DV,     0);
    chk("rst_busy", bus.o_Busy,   0);
    chk("rst_err",  bus.o_Err,    0);
    @(negedge i_Clock);
    i_Reset = 1'b0;

    conv(8'h31, -1, 8'h00, edges, busy_n, res, err);
    chk("31_latency", edges,  13);
    chk("31_bin",     res,    31);
    chk("31_busy",    busy_n, 13);
    chk("31_err",     err,    0);
    @(negedge i_Clock);
    chk("31_dv_one",  bus.o_DV,     0);
    chk("31_hold",    bus.o_Binary, 31);

    conv(8'h18, 3, 8'h99, edges, busy_n, res, err);
    chk("18_latched", res, 18);

    conv(8'h00, -1, 8'h00, edges, busy_n, res, err);
    chk("00_bin", res, 0);
    chk("00_err", err, 0);
    conv(8'h99, -1, 8'h00, edges, busy_n, res, err);
    chk("99_bin", res, 99);
    chk("99_err", err, 0);

    // Held start: results every 2*OUTPUT_WIDTH cycles.
    @(negedge i_Clock);
    bus.i_BCD   = 8'h42;
    bus.i_Start = 1'b1;
    for (int k = 0; k < 60 && dv_at.size() < 3; k++) begin
      @(negedge i_Clock);
      if (bus.o_DV) begin
        dv_at.push_back(k);
        chk("b2b_bin", bus.o_Binary, 42);
      end
    end
    chk("b2b_count", dv_at.size(), 3);
    if (dv_at.size() == 3) begin
      chk("b2b_gap0", dv_at[1] - dv_at[0], 14);
      chk("b2b_gap1", dv_at[2] - dv_at[1], 14);
    end
    bus.i_Start = 1'b0;
    repeat (20) @(negedge i_Clock);

    // Reset in the middle of an 8'h77 conversion.
    bus.i_BCD   = 8'h77;
    bus.i_Start = 1'b1;
    @(posedge i_Clock);
    #1 bus.i_Start = 1'b0;
    repeat (5) @(posedge i_Clock);
    #2 i_Reset = 1'b1;
    #1;
    chk("abort_bin",  bus.o_Binary, 0);
    chk("abort_dv",   bus.o_DV,     0);
    chk("abort_busy", bus.o_Busy,   0);
    chk("abort_err",  bus.o_Err,    0);
    @(negedge i_Clock);
    i_Reset = 1'b0;
    dv_seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge i_Clock);
      if (bus.o_DV) dv_seen++;
    end
    chk("abort_no_dv", dv_seen, 0);
    conv(8'h77, -1, 8'h00, edges, busy_n, res, err);
    chk("77_latency", edges, 13);
    chk("77_bin",     res,   77);

    conv(8'h1A, -1, 8'h00, edges, busy_n, res, err);
`ifdef BCD2BIN_DIGIT_CHECK_EN
    chk("1A_bin", res, 0);
    chk("1A_err", err, 1);
`else
    chk("1A_bin", res, 20);
    chk("1A_err", err, 0);
`endif
    last_dv = edges;
    chk("1A_latency", last_dv, 13);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
